// File: rtl/filter_config_sequencer.sv
// Frame-synchronous mode controller for the VGA filter pipeline: debounced buttons and
// beat-driven auto-advance request mode changes, which are committed only at frame_start.
module filter_config_sequencer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int BEATS_PER_MODE  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] key_n,
  input  logic       frame_start,
  input  logic       beat_pulse,
  output logic [1:0] mode,
  output logic       thresh_enable,
  output logic       bright_enable,
  output logic       adsr_enable,
  output logic       kernel_sel,
  output logic       auto_mode,
  output logic       pending,
  output logic       cfg_update,
  output logic [1:0] dbg_state
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BCW = (BEATS_PER_MODE > 1) ? $clog2(BEATS_PER_MODE) : 1;
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BCW-1:0] BEAT_LAST = BCW'(BEATS_PER_MODE - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_APPLY   = 2'd2
  } state_e;

  logic [2:0]          key_meta_q, key_sync_q;
  logic                beat_meta_q, beat_sync_q, beat_prev_q;
  logic [2:0]          db_level_q, db_level_d;
  logic [2:0][DBW-1:0] db_cnt_q, db_cnt_d;
  logic [2:0]          press_q, press_d;
  logic [BCW-1:0]      beat_cnt_q, beat_cnt_d;
  logic                auto_q, auto_d;
  state_e              state_q, state_d;
  logic [1:0]          target_q, target_d;
  logic [1:0]          mode_q, mode_d;

  logic       next_ev, prev_ev, tog_ev;
  logic       beat_rise, auto_req;
  logic [1:0] man_delta, delta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_meta_q  <= 3'b111;
      key_sync_q  <= 3'b111;
      beat_meta_q <= 1'b0;
      beat_sync_q <= 1'b0;
      beat_prev_q <= 1'b0;
      db_level_q  <= 3'b111;
      db_cnt_q    <= '0;
      press_q     <= '0;
      beat_cnt_q  <= '0;
      auto_q      <= 1'b0;
      state_q     <= ST_IDLE;
      target_q    <= '0;
      mode_q      <= '0;
    end else begin
      key_meta_q  <= key_n;
      key_sync_q  <= key_meta_q;
      beat_meta_q <= beat_pulse;
      beat_sync_q <= beat_meta_q;
      beat_prev_q <= beat_sync_q;
      db_level_q  <= db_level_d;
      db_cnt_q    <= db_cnt_d;
      press_q     <= press_d;
      beat_cnt_q  <= beat_cnt_d;
      auto_q      <= auto_d;
      state_q     <= state_d;
      target_q    <= target_d;
      mode_q      <= mode_d;
    end
  end

  // A key level is accepted once it has differed from the debounced level for
  // DEBOUNCE_CYCLES consecutive cycles; a press is the accepted fall to 0.
  always_comb begin
    db_level_d = db_level_q;
    db_cnt_d   = db_cnt_q;
    press_d    = '0;
    for (int k = 0; k < 3; k++) begin
      if (key_sync_q[k] == db_level_q[k]) begin
        db_cnt_d[k] = '0;
      end else if (db_cnt_q[k] == DB_LAST) begin
        db_cnt_d[k]   = '0;
        db_level_d[k] = key_sync_q[k];
        press_d[k]    = ~key_sync_q[k];
      end else begin
        db_cnt_d[k] = db_cnt_q[k] + 1'b1;
      end
    end
  end

  assign next_ev   = press_q[0];
  assign prev_ev   = press_q[1];
  assign tog_ev    = press_q[2];
  assign beat_rise = beat_sync_q & ~beat_prev_q;
  assign auto_req  = auto_q & beat_rise & (beat_cnt_q == BEAT_LAST);

  always_comb begin
    man_delta = 2'd0;
    case ({prev_ev, next_ev})
      2'b01:   man_delta = 2'd1;
      2'b10:   man_delta = 2'd3;
      default: man_delta = 2'd0;
    endcase
  end

  // Net delta is mod 4, so prev + auto cancels to zero like next + prev does.
  assign delta = man_delta + {1'b0, auto_req};

  always_comb begin
    auto_d     = auto_q ^ tog_ev;
    beat_cnt_d = beat_cnt_q;
    if (tog_ev || next_ev || prev_ev || auto_req) begin
      beat_cnt_d = '0;
    end else if (auto_q && beat_rise) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    mode_d   = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (delta != 2'd0) begin
          target_d = mode_q + delta;
          state_d  = ST_PENDING;
        end
      end
      ST_PENDING: begin
        target_d = target_q + delta;
        if (frame_start) begin
          mode_d  = target_q + delta;
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        // mode_q already holds the value just applied.
        if (delta != 2'd0) begin
          target_d = mode_q + delta;
          state_d  = ST_PENDING;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mode          = mode_q;
  assign thresh_enable = (mode_q == 2'd1) || (mode_q == 2'd3);
  assign bright_enable = (mode_q == 2'd2);
  assign adsr_enable   = (mode_q == 2'd2);
  assign kernel_sel    = (mode_q == 2'd3);
  assign auto_mode     = auto_q;
  assign pending       = (state_q == ST_PENDING);
  assign cfg_update    = (state_q == ST_APPLY);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_filter_config_sequencer.sv
// Bench for filter_config_sequencer: scenario tasks plus random operations, all checked
// against an arithmetic model of pending mode changes, beat counting and the mode table.
module tb_filter_config_sequencer;

  localparam int D   = 4;
  localparam int BPM = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] key_n = 3'b111;
  logic       frame_start = 1'b0;
  logic       beat_pulse = 1'b0;
  logic [1:0] mode;
  logic       thresh_enable, bright_enable, adsr_enable, kernel_sel;
  logic       auto_mode, pending, cfg_update;
  logic [1:0] dbg_state;
  logic [7:0] obs;

  int checks = 0;
  int errors = 0;
  int cfg_cnt = 0;

  int exp_mode = 0;
  int exp_target = 0;
  int exp_beats = 0;
  bit exp_pend = 1'b0;
  bit exp_auto = 1'b0;

  filter_config_sequencer #(.DEBOUNCE_CYCLES(D), .BEATS_PER_MODE(BPM)) dut (
    .clk           (clk),
    .reset         (reset),
    .key_n         (key_n),
    .frame_start   (frame_start),
    .beat_pulse    (beat_pulse),
    .mode          (mode),
    .thresh_enable (thresh_enable),
    .bright_enable (bright_enable),
    .adsr_enable   (adsr_enable),
    .kernel_sel    (kernel_sel),
    .auto_mode     (auto_mode),
    .pending       (pending),
    .cfg_update    (cfg_update),
    .dbg_state     (dbg_state)
  );

  always #5 clk = ~clk;

  assign obs = {mode, thresh_enable, bright_enable, adsr_enable, kernel_sel, auto_mode, pending};

  always @(negedge clk) if (cfg_update === 1'b1) cfg_cnt++;

  // ---------------- reference model ----------------
  function automatic logic [7:0] exp_vec();
    logic [3:0] en_tab [4];
    en_tab[0] = 4'b0000;
    en_tab[1] = 4'b1000;
    en_tab[2] = 4'b0110;
    en_tab[3] = 4'b1001;
    return {2'(exp_mode), en_tab[exp_mode], exp_auto, exp_pend};
  endfunction

  function automatic void model_reset();
    exp_mode = 0; exp_target = 0; exp_beats = 0; exp_pend = 1'b0; exp_auto = 1'b0;
  endfunction

  function automatic void model_request(int d);
    if (exp_pend) exp_target = (exp_target + d + 4) % 4;
    else if (((d % 4) + 4) % 4 != 0) begin
      exp_pend   = 1'b1;
      exp_target = (exp_mode + d + 4) % 4;
    end
  endfunction

  function automatic bit model_frame();
    if (!exp_pend) return 1'b0;
    exp_mode = exp_target;
    exp_pend = 1'b0;
    return 1'b1;
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    ticks(3);
    reset = 1'b1;
    tick();
    model_reset();
  endtask

  task automatic press_keys(input logic [2:0] mask);
    int d;
    key_n = ~mask;
    ticks(10);
    key_n = 3'b111;
    ticks(10);
    d = 0;
    if (mask[0] && !mask[1]) d = 1;
    else if (mask[1] && !mask[0]) d = -1;
    if (mask[0] || mask[1]) exp_beats = 0;
    if (mask[2]) begin
      exp_auto  = !exp_auto;
      exp_beats = 0;
    end
    if (d != 0) model_request(d);
  endtask

  task automatic beat_edge();
    beat_pulse = 1'b1;
    ticks(3);
    beat_pulse = 1'b0;
    ticks(3);
    if (exp_auto) begin
      exp_beats++;
      if (exp_beats == BPM) begin
        exp_beats = 0;
        model_request(1);
      end
    end
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bit ec;
    reset = 1'b0;
    model_reset();
    ticks(3);
    checks++;
    if (obs !== exp_vec()) begin
      errors++; $display("FAIL reset_hold: outputs got %b expected %b", obs, exp_vec());
    end
    reset = 1'b1;
    tick();
    checks++;
    if (obs !== exp_vec() || cfg_update !== 1'b0) begin
      errors++; $display("FAIL reset_release: outputs got %b cfg %b expected %b cfg 0", obs, cfg_update, exp_vec());
    end
    ec = model_frame();
    pulse_frame();
    checks++;
    if (cfg_update !== ec) begin
      errors++; $display("FAIL reset_frame_cfg: got %b expected %b", cfg_update, ec);
    end
  endtask

  task automatic test_next_press();
    int first;
    bit ec;
    first = 0;
    key_n[0] = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (pending === 1'b1 && first == 0) first = i;
    end
    key_n = 3'b111;
    ticks(10);
    exp_beats = 0;
    model_request(1);
    checks++;
    if (first < 6 || first > 9) begin
      errors++; $display("FAIL next_latency: pending after %0d cycles expected 6..9", first);
    end
    checks++;
    if (obs !== exp_vec()) begin
      errors++; $display("FAIL next_pending: outputs got %b expected %b", obs, exp_vec());
    end
    ec = model_frame();
    pulse_frame();
    checks++;
    if (cfg_update !== ec || obs !== exp_vec()) begin
      errors++; $display("FAIL next_apply: cfg %b outputs %b expected cfg %b outputs %b", cfg_update, obs, ec, exp_vec());
    end
    tick();
    checks++;
    if (cfg_update !== 1'b0 || obs !== exp_vec()) begin
      errors++; $display("FAIL next_after: cfg %b outputs %b expected cfg 0 outputs %b", cfg_update, obs, exp_vec());
    end
  endtask

  task automatic test_bounce();
    int pend_seen;
    bit ec;
    pend_seen = 0;
    for (int i = 0; i < 10; i++) begin
      key_n[0] = ~key_n[0];
      ticks(2);
      if (pending !== 1'b0) pend_seen++;
    end
    key_n = 3'b111;
    ticks(10);
    checks++;
    if (pend_seen != 0 || obs !== exp_vec()) begin
      errors++; $display("FAIL bounce: pending seen %0d outputs %b expected 0 and %b", pend_seen, obs, exp_vec());
    end
    ec = model_frame();
    pulse_frame();
    checks++;
    if (cfg_update !== ec) begin
      errors++; $display("FAIL bounce_frame: cfg got %b expected %b", cfg_update, ec);
    end
  endtask

  task automatic test_wrap_accum();
    bit ec;
    int c0;
    apply_reset();
    press_keys(3'b010);
    ec = model_frame();
    pulse_frame();
    checks++;
    if (cfg_update !== ec || obs !== exp_vec()) begin
      errors++; $display("FAIL wrap_prev: cfg %b outputs %b expected cfg %b outputs %b", cfg_update, obs, ec, exp_vec());
    end
    tick();
    press_keys(3'b001);
    press_keys(3'b001);
    c0 = cfg_cnt;
    ec = model_frame();
    pulse_frame();
    ticks(4);
    checks++;
    if (obs !== exp_vec() || (cfg_cnt - c0) != 1) begin
      errors++; $display("FAIL accum_two_next: outputs %b pulses %0d expected %b pulses 1", obs, cfg_cnt - c0, exp_vec());
    end
    press_keys(3'b011);
    checks++;
    if (obs !== exp_vec()) begin
      errors++; $display("FAIL next_prev_cancel: outputs got %b expected %b", obs, exp_vec());
    end
    ec = model_frame();
    pulse_frame();
    checks++;
    if (cfg_update !== ec) begin
      errors++; $display("FAIL cancel_frame: cfg got %b expected %b", cfg_update, ec);
    end
    tick();
  endtask

  task automatic test_auto();
    bit ec;
    apply_reset();
    press_keys(3'b100);
    checks++;
    if (obs !== exp_vec()) begin
      errors++; $display("FAIL auto_on: outputs got %b expected %b", obs, exp_vec());
    end
    for (int p = 0; p < 2; p++) begin
      beat_edge();
      beat_edge();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL auto_pending_%0d: outputs got %b expected %b", p, obs, exp_vec());
      end
      ec = model_frame();
      pulse_frame();
      checks++;
      if (cfg_update !== ec || obs !== exp_vec()) begin
        errors++; $display("FAIL auto_apply_%0d: cfg %b outputs %b expected cfg %b outputs %b", p, cfg_update, obs, ec, exp_vec());
      end
      tick();
    end
    press_keys(3'b100);
    for (int i = 0; i < 4; i++) beat_edge();
    checks++;
    if (obs !== exp_vec()) begin
      errors++; $display("FAIL auto_off: outputs got %b expected %b", obs, exp_vec());
    end
    ec = model_frame();
    pulse_frame();
    checks++;
    if (cfg_update !== ec) begin
      errors++; $display("FAIL auto_off_frame: cfg got %b expected %b", cfg_update, ec);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bit ec;
    press_keys(3'b001);
    ec = model_frame();
    frame_start = 1'b1;
    tick();
    checks++;
    if (cfg_update !== ec || obs !== exp_vec()) begin
      errors++; $display("FAIL b2b_first: cfg %b outputs %b expected cfg %b outputs %b", cfg_update, obs, ec, exp_vec());
    end
    ec = model_frame();
    tick();
    frame_start = 1'b0;
    checks++;
    if (cfg_update !== ec || obs !== exp_vec()) begin
      errors++; $display("FAIL b2b_second: cfg %b outputs %b expected cfg %b outputs %b", cfg_update, obs, ec, exp_vec());
    end
    tick();
  endtask

  task automatic test_reset_pending();
    int c0;
    press_keys(3'b001);
    checks++;
    if (pending !== 1'b1) begin
      errors++; $display("FAIL rst_pend_setup: pending got %b expected 1", pending);
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs !== exp_vec() || cfg_update !== 1'b0) begin
      errors++; $display("FAIL rst_pend_async: outputs %b cfg %b expected %b cfg 0", obs, cfg_update, exp_vec());
    end
    ticks(2);
    reset = 1'b1;
    tick();
    c0 = cfg_cnt;
    pulse_frame();
    ticks(3);
    checks++;
    if (obs !== exp_vec() || cfg_cnt != c0) begin
      errors++; $display("FAIL rst_pend_frame: outputs %b pulses %0d expected %b pulses 0", obs, cfg_cnt - c0, exp_vec());
    end
  endtask

  task automatic test_random();
    int op;
    bit ec;
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 5);
      ec = 1'b0;
      case (op)
        0: press_keys(3'b001);
        1: press_keys(3'b010);
        2: press_keys(3'b011);
        3: begin
          ec = model_frame();
          pulse_frame();
        end
        4: beat_edge();
        default: press_keys(3'b100);
      endcase
      checks++;
      if (obs !== exp_vec() || cfg_update !== ec) begin
        errors++; $display("FAIL random_%0d_op%0d: outputs %b cfg %b expected %b cfg %b", n, op, obs, cfg_update, exp_vec(), ec);
      end
      if (op == 3) tick();
    end
  endtask

  initial begin
    test_reset();
    test_next_press();
    test_bounce();
    test_wrap_accum();
    test_auto();
    test_back_to_back();
    test_reset_pending();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
